// File: rtl/sc_stream_engine.sv
// sc_stream_engine: stream-cipher engine on the UART character path.
// It takes command characters from the receive side: L loads the key,
// E encrypts to hex pairs, D decrypts hex pairs and P reseeds the LFSR.
// Output goes to the transmit buffer through a ready/valid handshake,
// and rx_ready drops while a result is waiting to be sent.
module sc_stream_engine #(
   parameter int          KEY_NIBBLES   = 8,
   parameter logic [31:0] TAPS          = 32'h80200003,
   parameter logic [7:0]  NONPRINT_CHAR = 8'h2E
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       print_buf,
   output logic       key_err,
   output logic [2:0] mode
);

   localparam int W  = 4 * KEY_NIBBLES;
   localparam int CW = $clog2(KEY_NIBBLES + 1);
   localparam logic [W+31:0] TAPS_X = {{W{1'b0}}, TAPS};
   localparam logic [W-1:0]  TAPS_W = TAPS_X[W-1:0];
   localparam logic [CW-1:0] LAST_NIB = CW'(KEY_NIBBLES - 1);
   localparam logic [7:0]    CR = 8'h0D;

   typedef enum logic [1:0] {S_IDLE, S_KEY, S_ENC, S_DEC} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   lfsr_q, lfsr_d;
   logic [W-1:0]   key_q, key_d;
   logic [W-1:0]   shadow_q, shadow_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     nib_q, nib_d;
   logic           half_q, half_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           tx_valid_q, tx_valid_d;
   logic           pend_q, pend_d;
   logic [7:0]     pend_data_q, pend_data_d;
   logic           print_buf_q, print_buf_d;
   logic           key_err_q, key_err_d;

   logic           acc;
   logic [W+7:0]   lfsr_ext;
   logic [7:0]     psr;
   logic [7:0]     xb;
   logic [W-1:0]   shadow_n;

   function automatic logic is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      // Letters A-F and a-f share the low nibble 1..6, so +9 covers both cases.
      return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
   endfunction

   function automatic logic [7:0] to_hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic is_print(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

   function automatic logic [W-1:0] lfsr_load(input logic [W-1:0] k);
      // An all-zero seed would lock the LFSR, so it is replaced with 1.
      return (k == '0) ? W'(1) : k;
   endfunction

   function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] l);
      return {l[W-2:0], ^(l & TAPS_W)};
   endfunction

   // Zero-extend before taking the low byte so that narrow LFSRs still form an 8-bit keystream.
   assign lfsr_ext = {8'h00, lfsr_q};
   assign psr      = lfsr_ext[7:0];
   assign rx_ready = ~tx_valid_q;
   assign acc      = rx_valid & rx_ready;
   assign xb       = rx_data ^ psr;
   assign shadow_n = (shadow_q << 4) | W'(hex_val(rx_data));

   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign print_buf = print_buf_q;
   assign key_err   = key_err_q;

   // LED mode decodes the state; it is all-zero in IDLE.
   always_comb begin
      mode = 3'b000;
      case (state_q)
         S_KEY:   mode = 3'b001;
         S_ENC:   mode = 3'b010;
         S_DEC:   mode = 3'b100;
         default: mode = 3'b000;
      endcase
   end

   // Next-state logic: command FSM, key entry, cipher datapath and tx handshake.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      key_d       = key_q;
      shadow_d    = shadow_q;
      cnt_d       = cnt_q;
      nib_d       = nib_q;
      half_d      = half_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      print_buf_d = 1'b0;
      key_err_d   = 1'b0;

      // Present the second hex digit after the first is taken; otherwise release the slot.
      if (tx_valid_q && tx_ready) begin
         if (pend_q) begin
            tx_data_d = pend_data_q;
            pend_d    = 1'b0;
         end else begin
            tx_valid_d = 1'b0;
         end
      end

      // acc implies tx_valid_q == 0, so a new result never collides with a transfer in flight.
      if (acc) begin
         case (state_q)
            S_IDLE: begin
               if (rx_data == 8'h4C) begin
                  state_d  = S_KEY;
                  cnt_d    = '0;
                  shadow_d = '0;
               end else if (rx_data == 8'h45) begin
                  state_d = S_ENC;
                  lfsr_d  = lfsr_load(key_q);
               end else if (rx_data == 8'h44) begin
                  state_d = S_DEC;
                  half_d  = 1'b0;
                  lfsr_d  = lfsr_load(key_q);
               end else if (rx_data == 8'h50) begin
                  lfsr_d = lfsr_load(key_q);
               end
            end
            S_KEY: begin
               if (is_hex(rx_data)) begin
                  shadow_d = shadow_n;
                  if (cnt_q == LAST_NIB) begin
                     key_d   = shadow_n;
                     lfsr_d  = lfsr_load(shadow_n);
                     state_d = S_IDLE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  key_err_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
            S_ENC: begin
               if (rx_data == CR) begin
                  print_buf_d = 1'b1;
                  state_d     = S_IDLE;
               end else if (is_print(rx_data)) begin
                  tx_data_d   = to_hex(xb[7:4]);
                  tx_valid_d  = 1'b1;
                  pend_d      = 1'b1;
                  pend_data_d = to_hex(xb[3:0]);
                  lfsr_d      = lfsr_step(lfsr_q);
               end
            end
            default: begin
               if (rx_data == CR) begin
                  print_buf_d = 1'b1;
                  half_d      = 1'b0;
                  state_d     = S_IDLE;
               end else if (is_hex(rx_data)) begin
                  if (!half_q) begin
                     nib_d  = hex_val(rx_data);
                     half_d = 1'b1;
                  end else begin
                     tx_data_d  = is_print({nib_q, hex_val(rx_data)} ^ psr) ?
                                  ({nib_q, hex_val(rx_data)} ^ psr) : NONPRINT_CHAR;
                     tx_valid_d = 1'b1;
                     pend_d     = 1'b0;
                     half_d     = 1'b0;
                     lfsr_d     = lfsr_step(lfsr_q);
                  end
               end
            end
         endcase
      end
   end

   // State register; every register, including the key, returns to its reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lfsr_q      <= W'(1);
         key_q       <= '0;
         shadow_q    <= '0;
         cnt_q       <= '0;
         nib_q       <= '0;
         half_q      <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         pend_q      <= 1'b0;
         pend_data_q <= 8'h00;
         print_buf_q <= 1'b0;
         key_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         key_q       <= key_d;
         shadow_q    <= shadow_d;
         cnt_q       <= cnt_d;
         nib_q       <= nib_d;
         half_q      <= half_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         print_buf_q <= print_buf_d;
         key_err_q   <= key_err_d;
      end
   end

endmodule

// File: doc/sc_stream_engine.md
Name: sc_stream_engine

Overview:
Parametrised stream-cipher engine for the UART character path. It accepts command characters from the UART receive side:
- 'L' loads the key.
- 'E' encrypts printable characters into hex pairs.
- 'D' decrypts hex pairs back into printable characters.
- 'P' reseeds the LFSR.

It generalises the fixed 32-bit, no-backpressure cipher to a configurable key/LFSR width, adds a real command FSM, a tx ready/valid handshake with rx stall, key-error detection and zero-seed protection.

Parameters:
KEY_NIBBLES, 8, number of 4-bit key digits; LFSR width W = 4*KEY_NIBBLES (min 2)
TAPS, 32'h80200003, feedback tap mask (low W bits used)
NONPRINT_CHAR, 8'h2E, substituted for non-printable decrypted bytes

Ports:
clk  in  1  clock
rst  in  1  reset
rx_data  in  8  UART receive byte
rx_valid  in  1  rx_data valid this cycle
rx_ready  out  1  engine can accept a byte
tx_data  out  8  byte to UART transmit buffer
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  transmit buffer accepts tx_data
print_buf  out  1  one-cycle pulse: flush transmit buffer
key_err  out  1  one-cycle pulse: bad key digit
mode  out  3  one-hot {DEC,ENC,KEY}; 0 in IDLE (LED drive)

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk.
- Reset values:
  - state=IDLE, lfsr=1, key=0.
  - tx_valid=0, tx_data=0, print_buf=0, key_err=0, rx_ready=1, mode=0.
- Accept: a byte is accepted on any cycle with rx_valid & rx_ready. rx_valid while rx_ready=0 is ignored; it is not queued.
- Hex digits are 0-9, A-F, a-f. Hex output is uppercase ASCII.
- LFSR:
  - step: lfsr <= {lfsr[W-2:0], ^(lfsr & TAPS[W-1:0])}.
  - psr = lfsr[7:0].
  - load: lfsr <= key, or W'h1 if key==0.
- IDLE:
  - 'L' -> KEY with nibble count=0.
  - 'E' -> ENC and 'D' -> DEC; both load the LFSR that cycle.
  - 'P' loads the LFSR and stays in IDLE.
  - All other bytes are ignored.
- KEY:
  - Each hex digit shifts into a shadow register, MS nibble first.
  - After KEY_NIBBLES digits: key <= shadow, load LFSR, -> IDLE.
  - Non-hex (including CR): pulse key_err, key unchanged, -> IDLE.
- ENC:
  - Printable byte c (0x20-0x7E) accepted at cycle t. At t+1: tx_data = hex(MS nibble of c^psr), tx_valid=1.
  - LFSR steps at t, after the XOR uses the pre-step value.
  - rx_ready=0 until both digits have been accepted by tx_ready. The MS digit goes first, then the LS digit.
- DEC:
  - The first hex digit latches the MS nibble. The second hex digit at cycle t gives, at t+1, tx_data = b^psr, or NONPRINT_CHAR if not printable. The LFSR steps at t.
  - rx_ready=0 until tx_ready.
  - Non-hex bytes other than CR are ignored, and the nibble phase is preserved.
- CR (0x0D) in ENC or DEC: pulse print_buf at t+1 and -> IDLE.
  - A CR with an odd pending DEC nibble drops that nibble.
  - The CR is not transmitted.
- Other non-printables in ENC are ignored, with no LFSR step.
- tx_valid=1 with tx_ready=0: tx_data and tx_valid hold stable indefinitely.
- tx_valid & tx_ready: the next digit is presented the following cycle, or tx_valid drops.
- rst mid-operation: any pending tx is discarded and all registers return to reset values, including key=0.
- mode follows state combinationally.

Test Plan:
1. rst; send "L00000041" -> key=0x00000041, lfsr=0x00000041, no key_err, mode returns to 0.
2. After test 1, send "E", 'A', 'B', CR -> tx "0","0" (0x30,0x30), then "C","1" (0x43,0x31); print_buf pulses once; lfsr=0x00000106.
3. After test 1, send "D", "00", "C1", CR -> tx 'A' (0x41), then 'B' (0x42); print_buf pulse.
4. rst; send "E", 'A' (zero key, so lfsr=1) -> tx "4","0" (0x34,0x30).
5. Hold tx_ready=0 for 10 cycles during test 2 -> tx_data stays 0x30 with tx_valid=1; rx_ready=0; 'B' offered meanwhile is dropped.
6. Send "L00G" -> key_err pulse at 'G', key unchanged, state IDLE; then "L0000004" followed by CR -> key_err pulse again.
